// File: rtl/svi_array_stream_fanout_pkg.sv
// Shared defaults and helpers for the stream fan-out block and its slot/interface.
package svi_fanout_pkg;

    localparam int DEF_N_CH  = 8;
    localparam int DEF_W     = 8;
    localparam int DEF_CNT_W = 16;

    // Index width for a channel count; a single channel still gets one bit so
    // that index 1 exists as the out-of-range error path.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/svi_array_stream_fanout_if.sv
// One downstream valid/ready/data stream; the fan-out drives it as master.
interface svi_stream_if
    import svi_fanout_pkg::*;
#(
    parameter int W = DEF_W
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/svi_array_stream_fanout_slot.sv
// Single-entry holding register for one channel, with a delivered-beat counter.
// A slot being drained in this cycle is reported free so it can reload at once.
module svi_fanout_slot
    import svi_fanout_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             ready,
    output logic             valid,
    output logic [W-1:0]     data,
    output logic [CNT_W-1:0] cnt,
    output logic             free
);

    logic drain;

    assign drain = valid && ready;
    assign free  = !valid || ready;

    // Load wins over drain so a simultaneous drain+load keeps the slot full with new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            cnt   <= '0;
        end else begin
            if (drain) begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                valid <= 1'b1;
                data  <= load_data;
            end else if (drain) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/svi_array_stream_fanout.sv
// Steers one upstream tagged stream into per-channel one-entry slots (unicast
// or broadcast) and presents each slot on its own downstream stream interface.
module svi_array_stream_fanout
    import svi_fanout_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [idx_width(N_CH)-1:0] i_ch,
    input  logic                      i_bcast,
    input  logic [W-1:0]              i_data,
    svi_stream_if.master              u_ch [N_CH],
    output logic [N_CH-1:0]           o_busy,
    output logic [N_CH*CNT_W-1:0]     o_cnt,
    output logic                      o_err
);

    logic [31:0]      ch_ext;
    logic             ch_in_range;
    logic             sel_free;
    logic             accept;
    logic [N_CH-1:0]  free_w;
    logic [N_CH-1:0]  valid_w;
    logic [N_CH-1:0]  ready_w;
    logic [N_CH-1:0]  load_w;
    logic [W-1:0]     data_w [N_CH];
    logic [CNT_W-1:0] cnt_w  [N_CH];

    assign ch_ext      = 32'(i_ch);
    assign ch_in_range = (ch_ext < N_CH);

    // Pick the free flag of the addressed channel; a loop avoids indexing past N_CH.
    always_comb begin
        sel_free = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_ext == k) begin
                sel_free = free_w[k];
            end
        end
    end

    // Broadcast needs every slot free; out-of-range unicast is always taken and dropped.
    always_comb begin
        o_ready = 1'b1;
        if (i_bcast) begin
            o_ready = &free_w;
        end else if (ch_in_range) begin
            o_ready = sel_free;
        end
    end

    assign accept = i_valid && o_ready;
    assign o_busy = valid_w;

    // Flag a dropped unicast beat for exactly one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else begin
            o_err <= accept && !i_bcast && !ch_in_range;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        assign load_w[k]  = accept && (i_bcast || (ch_ext == k));
        assign ready_w[k] = u_ch[k].ready;

        svi_fanout_slot #(
            .W     (W),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk       (i_clk),
            .rst       (i_rst),
            .load      (load_w[k]),
            .load_data (i_data),
            .ready     (ready_w[k]),
            .valid     (valid_w[k]),
            .data      (data_w[k]),
            .cnt       (cnt_w[k]),
            .free      (free_w[k])
        );

        assign u_ch[k].valid = valid_w[k];
        assign u_ch[k].data  = data_w[k];
        assign o_cnt[k*CNT_W +: CNT_W] = cnt_w[k];
    end

endmodule

// File: tb/tb_svi_array_stream_fanout.sv
// Randomized and directed bench for the stream fan-out against a beat-level model.
module tb_svi_array_stream_fanout;
    import svi_fanout_pkg::*;

    localparam int N_CH  = 6;
    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int IW    = idx_width(N_CH);

    logic                  i_clk = 1'b0;
    logic                  i_rst = 1'b1;
    logic                  i_valid = 1'b0;
    logic                  o_ready;
    logic [IW-1:0]         i_ch = '0;
    logic                  i_bcast = 1'b0;
    logic [W-1:0]          i_data = '0;
    logic [N_CH-1:0]       o_busy;
    logic [N_CH*CNT_W-1:0] o_cnt;
    logic                  o_err;
    logic [N_CH-1:0]       ds_ready = '0;
    logic [N_CH-1:0]       ch_valid;
    logic [W-1:0]          ch_data [N_CH];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: what each channel is holding, how many beats it delivered, pending error.
    bit       m_full [N_CH];
    int       m_data [N_CH];
    int       m_cnt  [N_CH];
    bit       m_err;

    svi_stream_if #(.W(W)) u_ch [N_CH] ();

    svi_array_stream_fanout #(
        .N_CH  (N_CH),
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_ch    (i_ch),
        .i_bcast (i_bcast),
        .i_data  (i_data),
        .u_ch    (u_ch),
        .o_busy  (o_busy),
        .o_cnt   (o_cnt),
        .o_err   (o_err)
    );

    for (genvar k = 0; k < N_CH; k++) begin : g_hook
        assign u_ch[k].ready = ds_ready[k];
        assign ch_valid[k]   = u_ch[k].valid;
        assign ch_data[k]    = u_ch[k].data;
    end

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic bit modelReady();
        bit all_free = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            if (m_full[k] && !ds_ready[k]) all_free = 1'b0;
        end
        if (i_bcast) return all_free;
        if (int'(i_ch) >= N_CH) return 1'b1;
        return !m_full[i_ch] || ds_ready[i_ch];
    endfunction

    task automatic modelClear();
        for (int k = 0; k < N_CH; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = 0;
            m_cnt[k]  = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic compareAll();
        logic [63:0] exp_busy = '0;
        logic [63:0] exp_cnt  = '0;
        for (int k = 0; k < N_CH; k++) begin
            exp_busy[k] = m_full[k];
            exp_cnt     = exp_cnt | (64'(m_cnt[k] % (1 << CNT_W)) << (k * CNT_W));
        end
        checkOutput("o_ready", 64'(o_ready), 64'(modelReady()));
        checkOutput("o_busy", 64'(o_busy), exp_busy);
        checkOutput("u_ch.valid", 64'(ch_valid), exp_busy);
        checkOutput("o_cnt", 64'(o_cnt), exp_cnt);
        checkOutput("o_err", 64'(o_err), 64'(m_err));
        for (int k = 0; k < N_CH; k++) begin
            if (m_full[k]) checkOutput($sformatf("u_ch[%0d].data", k), 64'(ch_data[k]), 64'(m_data[k]));
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelStep();
        bit acc = i_valid && modelReady();
        m_err = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (m_full[k] && ds_ready[k]) begin
                m_full[k] = 1'b0;
                m_cnt[k]  = (m_cnt[k] + 1) % (1 << CNT_W);
            end
        end
        if (acc) begin
            if (i_bcast) begin
                for (int k = 0; k < N_CH; k++) begin
                    m_full[k] = 1'b1;
                    m_data[k] = int'(i_data);
                end
            end else if (int'(i_ch) < N_CH) begin
                m_full[i_ch] = 1'b1;
                m_data[i_ch] = int'(i_data);
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input bit v, input int ch, input bit b, input int d, input logic [N_CH-1:0] rdy);
        i_valid  = v;
        i_ch     = IW'(ch);
        i_bcast  = b;
        i_data   = W'(d);
        ds_ready = rdy;
        @(negedge i_clk);
        compareAll();
        modelStep();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyReset(input logic [N_CH-1:0] rdy);
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        ds_ready = rdy;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        modelClear();
    endtask

    initial begin
        modelClear();
        applyReset('0);
        applyStimulus(0, 0, 0, 0, '0);

        // Unicast to ch 3 held by ready=0, second beat blocked, then drained.
        applyStimulus(1, 3, 0, 'hA5, '0);
        applyStimulus(1, 3, 0, 'h5A, '0);
        applyStimulus(0, 3, 0, 0, 6'b001000);
        applyStimulus(0, 0, 0, 0, '0);

        // Back-to-back stream of 16 beats to ch 5 with ready held high.
        for (int i = 0; i < 16; i++) applyStimulus(1, 5, 0, 'h10 + i, 6'b100000);
        applyStimulus(0, 5, 0, 0, 6'b100000);

        // Broadcast blocked by a full, stalled slot 2, then released.
        applyStimulus(1, 2, 0, 'h77, '0);
        applyStimulus(1, 0, 1, 'h3C, 6'b111011);
        applyStimulus(1, 0, 1, 'h3C, 6'b111111);
        applyStimulus(0, 0, 0, 0, '0);
        applyStimulus(0, 0, 0, 0, '1);

        // Out-of-range unicast indices are dropped with an error pulse.
        applyStimulus(1, 1, 0, 'h11, '0);
        applyStimulus(1, 7, 0, 'hEE, '0);
        applyStimulus(1, 6, 0, 'hDD, '0);
        applyStimulus(0, 0, 0, 0, '0);

        // Reset with three busy slots; drains during reset must not count.
        applyStimulus(1, 0, 0, 'hAA, '0);
        applyStimulus(1, 4, 0, 'hBB, '0);
        applyReset('1);
        applyStimulus(0, 0, 0, 0, '0);

        // Counter wrap: 17 drains on ch 0 with a 4-bit counter.
        for (int i = 0; i < 17; i++) applyStimulus(1, 0, 0, i, 6'b000001);
        applyStimulus(0, 0, 0, 0, 6'b000001);

        // Random traffic mix.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                          bit'($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)),
                          N_CH'($urandom));
        end
        applyStimulus(0, 0, 0, 0, '1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/svi_array_stream_fanout.md
Name: svi_array_stream_fanout

Overview:
- Successor to the fixed-size, literal-driven interface-array block: parametrised channel count and data width, real per-channel handshake and buffering.
- Accepts one upstream stream tagged with a destination channel. Steers each beat into a one-entry holding slot per channel.
- Drives an unpacked array of stream interfaces (valid/ready/data) toward downstream consumers.
- Supports unicast and broadcast writes, plus per-channel delivered-beat counters.

Parameters:
- N_CH, 8, number of channels; size of the interface array; ≥ 1.
- W, 8, data width per beat.
- CNT_W, 16, width of each per-channel delivered-beat counter.

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_rst  input  1  synchronous reset, active-high.
- i_valid  input  1  upstream beat valid.
- o_ready  output  1  upstream beat accepted when i_valid && o_ready.
- i_ch  input  $clog2(N_CH) (min 1)  destination channel index; ignored when i_bcast=1.
- i_bcast  input  1  beat goes to every channel.
- i_data  input  W  beat payload.
- u_ch  interface array  [N_CH]  stream interface per channel with members valid (driven), ready (sampled), data[W-1:0] (driven). Declared as an unpacked array, C-style size.
- o_busy  output  N_CH  bit k = slot k holds an undelivered beat.
- o_cnt  output  N_CH×CNT_W  packed per-channel delivered-beat counters.
- o_err  output  1  one-cycle pulse: accepted unicast beat with i_ch ≥ N_CH.

Behaviour:
- Interface:
  - Single clock i_clk.
  - Reset i_rst is synchronous and active-high.
  - Reset is sampled only on posedge i_clk.
- Reset values: all slot valid = 0, slot data = 0, o_cnt = 0, o_err = 0, o_busy = 0.
  - o_ready is combinational from slot state, so it reads 1 after reset.
- Slot k drives u_ch[k].valid and u_ch[k].data directly from registered slot state. No combinational path from i_* to the interface.
- Drain:
  - slot k is drained in a cycle when valid_k && u_ch[k].ready.
  - A drain increments cnt_k, which wraps modulo 2^CNT_W without saturating.
- Free_k = !valid_k || u_ch[k].ready. A slot being drained counts as free in the same cycle.
- o_ready:
  - unicast (i_bcast=0) → o_ready = Free[i_ch], or 1 if i_ch ≥ N_CH.
  - broadcast → o_ready = &Free.
  - o_ready depends on i_ch and i_bcast only, never on i_valid.
- Accept (i_valid && o_ready):
  - unicast to a valid channel: slot i_ch loads i_data and valid=1 next cycle.
  - broadcast: every slot loads i_data and valid=1 next cycle. All-or-nothing; no partial broadcast.
  - unicast to i_ch ≥ N_CH: beat is dropped and o_err=1 next cycle. No slot changes.
- Latency: a beat accepted at edge t appears on u_ch[k] in the cycle after edge t (1 cycle). Zero bubbles.
- Simultaneous drain and load on the same slot:
  - slot stays valid with the new data.
  - cnt increments for the drained beat.
  - This sustains 1 beat/cycle/channel.
- Drain without load: valid_k → 0 next cycle. Data is held, don't-care.
- Holding rule: valid_k, once set, stays 1 and data stays stable until drained.
- Reset mid-operation:
  - pending beats are discarded and counters cleared. No drain is counted in the reset cycle.
  - u_ch[k].valid is 0 in the cycle after the reset edge.
- N_CH=1: i_ch is 1 bit; index 1 is the error path.

Decomposition:
- Package svi_fanout_pkg holds:
  - default N_CH, W, CNT_W as localparams;
  - a function computing the index width (clog2 with min 1).
- The stream interface (valid, ready, data, parameter W) lives alongside the package and is not part of the module.
- One sub-module, svi_fanout_slot: a single-entry holding register with load/drain/counter, instantiated N_CH times in a generate loop.
- Per-element interface signals connect through assign inside the generate loop. Intermediate variables are used, not direct procedural writes to the interface array.

Test Plan:
- Reset then idle:
  - all u_ch[k].valid=0, o_cnt all 0, o_ready=1.
  - drive i_rst mid-stream with 3 slots busy → next cycle o_busy=0, counters 0.
- Unicast 0xA5 to ch 3 with ready[3]=0:
  - next cycle u_ch[3].valid=1 and data=0xA5.
  - second beat to ch 3 sees o_ready=0.
  - raise ready[3] → beat drained, cnt[3]=1.
- Back-to-back 16 beats to ch 5 with ready[5]=1:
  - o_ready held 1, one beat/cycle on u_ch[5].
  - cnt[5]=16, data order preserved.
- Broadcast 0x3C with ready[2]=0 and slot 2 full:
  - o_ready=0 and no slot changes.
  - release ready[2] → broadcast accepted same cycle.
  - all 8 slots show 0x3C next cycle.
- Unicast with i_ch=8 (N_CH=8, index width 3 → use N_CH=6, i_ch=7):
  - accepted, o_err pulses 1 cycle, o_busy unchanged.
- Counter wrap with CNT_W=4:
  - 17 drains on ch 0 → cnt[0]=1.
